vga_timing_ctrl: RTL and testbench

Raster sequencer for the Tetris display path. Produces the pixel strobe, `row`/`column` coordinates and `blank_n` consumed by the colour generator, plus VGA sync and frame-event pulses for the game logic. Runs from the system clock with an internal pixel-clock-enable divider. Default configuration is 640x480 @ 60 Hz from a 50 MHz clock.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_axis_fsm.sv | 69 ++++++
 rtl/vga_timing_ctrl.sv | 109 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared axis states and default 640x480@60 timing
package vga_timing_pkg;

    typedef enum logic [1:0] {
        AX_ACTIVE = 2'd0,
        AX_FP     = 2'd1,
        AX_SYNC   = 2'd2,
        AX_BP     = 2'd3
    } axis_state_e;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Counter width able to hold 0..longest_segment-1.
    function automatic int count_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// rtl/vga_axis_fsm.sv - one raster axis: ACTIVE/FP/SYNC/BP sequencer with segment counter
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FP_LEN     = DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BP_LEN     = DEF_H_BP,
    parameter int CW         = count_width(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output axis_state_e   state,
    output logic [CW-1:0] count,
    output logic          wrap
);

    if (ACTIVE_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_len_check
        $error("vga_axis_fsm: segment lengths must be non-zero");
    end

    axis_state_e   state_nxt;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] seg_last;
    logic          at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= AX_ACTIVE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        seg_last  = CW'(ACTIVE_LEN - 1);
        case (state)
            AX_ACTIVE: seg_last = CW'(ACTIVE_LEN - 1);
            AX_FP:     seg_last = CW'(FP_LEN - 1);
            AX_SYNC:   seg_last = CW'(SYNC_LEN - 1);
            AX_BP:     seg_last = CW'(BP_LEN - 1);
            default:   seg_last = CW'(ACTIVE_LEN - 1);
        endcase
        at_last = (count == seg_last);
        if (step) begin
            if (at_last) begin
                count_nxt = '0;
                case (state)
                    AX_ACTIVE: state_nxt = AX_FP;
                    AX_FP:     state_nxt = AX_SYNC;
                    AX_SYNC:   state_nxt = AX_BP;
                    AX_BP:     state_nxt = AX_ACTIVE;
                    default:   state_nxt = AX_ACTIVE;
                endcase
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    // Combinational so the next axis can step on the very same edge.
    assign wrap = step && at_last && (state == AX_BP);

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster sequencer: pixel divider, H/V axes, sync and frame pulses
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_en,
    output logic [8:0] row,
    output logic [9:0] column,
    output logic       blank_n,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start,
    output logic       vblank_start
);

    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HCW = count_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VCW = count_width(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_ctrl: CLK_DIV must be at least 1");
    end

    logic [DW-1:0]  div_cnt;
    logic           div_last;
    logic           tick;
    axis_state_e    h_state;
    axis_state_e    v_state;
    logic [HCW-1:0] h_count;
    logic [VCW-1:0] v_count;
    logic           h_wrap;
    logic           v_wrap;
    logic           v_enter_fp;

    assign div_last = (div_cnt == DW'(CLK_DIV - 1));
    assign tick     = en && div_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end
    end

    vga_axis_fsm #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP),
        .CW         (HCW)
    ) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (tick),
        .state (h_state),
        .count (h_count),
        .wrap  (h_wrap)
    );

    // The vertical axis advances once per completed line.
    vga_axis_fsm #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP),
        .CW         (VCW)
    ) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (h_wrap),
        .state (v_state),
        .count (v_count),
        .wrap  (v_wrap)
    );

    assign v_enter_fp = h_wrap && (v_state == AX_ACTIVE) && (v_count == VCW'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en       <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            pix_en       <= tick;
            frame_start  <= h_wrap && v_wrap;
            vblank_start <= v_enter_fp;
        end
    end

    assign column  = (h_state == AX_ACTIVE) ? 10'(h_count) : '0;
    assign row     = (v_state == AX_ACTIVE) ? 9'(v_count) : '0;
    assign blank_n = (h_state == AX_ACTIVE) && (v_state == AX_ACTIVE);
    assign hsync_n = (h_state != AX_SYNC);
    assign vsync_n = (v_state != AX_SYNC);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [24:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 10'd0};

    // default-parameter instance
    logic rst_d, en_d, d_pix_en, d_blank_n, d_hsync_n, d_vsync_n, d_fs, d_vb;
    logic [8:0] d_row;
    logic [9:0] d_column;
    logic [24:0] d_vec;
    assign d_vec = {d_pix_en, d_blank_n, d_hsync_n, d_vsync_n, d_fs, d_vb, d_row, d_column};

    vga_timing_ctrl u_def (
        .clk (clk), .rst (rst_d), .en (en_d), .pix_en (d_pix_en), .row (d_row),
        .column (d_column), .blank_n (d_blank_n), .hsync_n (d_hsync_n), .vsync_n (d_vsync_n),
        .frame_start (d_fs), .vblank_start (d_vb)
    );

    // scaled instance for whole-frame checks: 25 ticks/line, 19 lines, 950 clks/frame
    logic rst_m, en_m, m_pix_en, m_blank_n, m_hsync_n, m_vsync_n, m_fs, m_vb;
    logic [8:0] m_row;
    logic [9:0] m_column;

    vga_timing_ctrl #(
        .CLK_DIV (2), .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) u_mid (
        .clk (clk), .rst (rst_m), .en (en_m), .pix_en (m_pix_en), .row (m_row),
        .column (m_column), .blank_n (m_blank_n), .hsync_n (m_hsync_n), .vsync_n (m_vsync_n),
        .frame_start (m_fs), .vblank_start (m_vb)
    );

    // tiny instance checked against a position model
    logic rst_s, en_s, s_pix_en, s_blank_n, s_hsync_n, s_vsync_n, s_fs, s_vb;
    logic [8:0] s_row;
    logic [9:0] s_column;
    logic [24:0] s_vec;
    assign s_vec = {s_pix_en, s_blank_n, s_hsync_n, s_vsync_n, s_fs, s_vb, s_row, s_column};

    vga_timing_ctrl #(
        .CLK_DIV (1), .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_small (
        .clk (clk), .rst (rst_s), .en (en_s), .pix_en (s_pix_en), .row (s_row),
        .column (s_column), .blank_n (s_blank_n), .hsync_n (s_hsync_n), .vsync_n (s_vsync_n),
        .frame_start (s_fs), .vblank_start (s_vb)
    );

    typedef struct {
        int         tick;
        logic [9:0] col;
        logic [8:0] row;
        logic       blank_n;
        logic       hsync_n;
    } vec_t;

    vec_t tbl [11];
    int hp = 0;
    int vp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic small_cycle();
        logic hw, fs, vb;
        logic [24:0] exp;
        step();
        hw = (hp == 6);
        hp = hw ? 0 : hp + 1;
        fs = 1'b0;
        vb = 1'b0;
        if (hw) begin
            vb = (vp == 2);
            fs = (vp == 5);
            vp = (vp == 5) ? 0 : vp + 1;
        end
        exp = {1'b1, (hp < 4) && (vp < 3), hp != 5, vp != 4, fs, vb,
               9'((vp < 3) ? vp : 0), 10'((hp < 4) ? hp : 0)};
        check($sformatf("small_h%0d_v%0d", hp, vp), s_vec, exp);
    endtask

    initial begin
        int tick, first_pix, hs_low, row1_clk, row2_clk, hits, found, frozen_ok;
        int blank_cnt, vs_low, vs_first, vb_clk, vb_cnt, fs_clk, fs_cnt;

        tbl[0]  = '{1,    10'd1,   9'd0, 1'b1, 1'b1};
        tbl[1]  = '{639,  10'd639, 9'd0, 1'b1, 1'b1};
        tbl[2]  = '{640,  10'd0,   9'd0, 1'b0, 1'b1};
        tbl[3]  = '{655,  10'd0,   9'd0, 1'b0, 1'b1};
        tbl[4]  = '{656,  10'd0,   9'd0, 1'b0, 1'b0};
        tbl[5]  = '{751,  10'd0,   9'd0, 1'b0, 1'b0};
        tbl[6]  = '{752,  10'd0,   9'd0, 1'b0, 1'b1};
        tbl[7]  = '{799,  10'd0,   9'd0, 1'b0, 1'b1};
        tbl[8]  = '{800,  10'd0,   9'd1, 1'b1, 1'b1};
        tbl[9]  = '{801,  10'd1,   9'd1, 1'b1, 1'b1};
        tbl[10] = '{1440, 10'd0,   9'd1, 1'b0, 1'b1};

        rst_d = 1'b1; en_d = 1'b1;
        rst_m = 1'b1; en_m = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;
        repeat (2) @(negedge clk);
        check("def_reset", d_vec, RST_VEC);
        check("small_reset", s_vec, RST_VEC);

        // default timing: table vectors, hsync width, line period
        rst_d = 1'b0;
        tick = 0; first_pix = 0; hs_low = 0; row1_clk = 0; row2_clk = 0; hits = 0;
        for (int c = 1; c <= 3300; c++) begin
            step();
            if (d_pix_en) begin
                tick++;
                if (first_pix == 0) first_pix = c;
                for (int i = 0; i < 11; i++) begin
                    if (tbl[i].tick == tick) begin
                        hits++;
                        check($sformatf("tbl_tick%0d", tick),
                              {d_column, d_row, d_blank_n, d_hsync_n},
                              {tbl[i].col, tbl[i].row, tbl[i].blank_n, tbl[i].hsync_n});
                    end
                end
            end
            if (!d_hsync_n && c < 2000) hs_low++;
            if (d_row == 9'd1 && row1_clk == 0) row1_clk = c;
            if (d_row == 9'd2 && row2_clk == 0) row2_clk = c;
        end
        check("tbl_hits", hits, 11);
        check("first_pix_clk", first_pix, 2);
        check("hsync_low_clks", hs_low, 192);
        check("row1_clk", row1_clk, 1600);
        check("line_period", row2_clk - row1_clk, 1600);

        // en low for 50 clks at column 100
        found = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (d_pix_en && d_column == 10'd100) begin
                found = 1;
                break;
            end
        end
        check("wait_col100", found, 1);
        en_d = 1'b0;
        frozen_ok = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (d_pix_en || d_column != 10'd100 || d_row != 9'd2 || !d_blank_n) frozen_ok = 0;
        end
        check("en_freeze", frozen_ok, 1);
        en_d = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (d_pix_en) begin
                found = 1;
                break;
            end
        end
        check("resume_tick", found, 1);
        check("resume_col", d_column, 101);

        // whole frame on the scaled instance
        rst_m = 1'b0; en_m = 1'b1;
        tick = 0; blank_cnt = 0; vs_low = 0; vs_first = 0;
        vb_clk = 0; vb_cnt = 0; fs_clk = 0; fs_cnt = 0;
        for (int c = 1; c <= 1000; c++) begin
            step();
            if (m_pix_en) begin
                tick++;
                if (tick <= 475 && m_blank_n) blank_cnt++;
            end
            if (!m_vsync_n && c <= 950) begin
                vs_low++;
                if (vs_first == 0) vs_first = c;
            end
            if (m_vb) begin
                vb_cnt++;
                if (vb_clk == 0) vb_clk = c;
            end
            if (m_fs) begin
                fs_cnt++;
                if (fs_clk == 0) fs_clk = c;
            end
        end
        check("frame_active_ticks", blank_cnt, 192);
        check("vsync_low_clks", vs_low, 100);
        check("vsync_first_clk", vs_first, 700);
        check("vblank_clk", vb_clk, 600);
        check("vblank_count", vb_cnt, 1);
        check("frame_start_clk", fs_clk, 950);
        check("frame_start_count", fs_cnt, 1);

        // tiny raster: two frames tick-by-tick against the position model
        rst_s = 1'b0; en_s = 1'b1;
        hp = 0; vp = 0;
        for (int c = 0; c < 84; c++) small_cycle();
        check("small_two_frames_home", {hp[7:0], vp[7:0]}, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            if (vp == 1 && hp == 2) break;
            small_cycle();
        end

        // asynchronous reset between edges, then restart from (0,0)
        #2;
        rst_s = 1'b1;
        #1;
        check("async_rst_immediate", s_vec, RST_VEC);
        @(negedge clk);
        check("async_rst_held", s_vec, RST_VEC);
        rst_s = 1'b0;
        hp = 0; vp = 0;
        for (int c = 0; c < 10; c++) small_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
